// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register interface.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } i2c_tgt_state_e;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

  localparam logic [3:0] I2C_LAST_BIT = 4'd7;
  localparam logic [3:0] I2C_ACK_SLOT = 4'd8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one raw bus line: synchronizer, optional majority filter
// (`I2C_TARGET_GLITCH_FILTER_EN) and rise/fall detection.
module i2c_line_cond #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_raw,
  output logic level,
  output logic rise,
  output logic fall
);
  import i2c_pkg::*;

  logic [SYNC_STAGES-1:0] sync;
  logic                   filt;
  logic                   prev;

  // Metastability synchronizer; idle bus level is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], line_raw};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt_q;

  // Majority of three consecutive samples swallows single-clk pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist   <= 2'b11;
      filt_q <= 1'b1;
    end else begin
      hist   <= {hist[0], sync[SYNC_STAGES-1]};
      filt_q <= maj3(sync[SYNC_STAGES-1], hist[0], hist[1]);
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync[SYNC_STAGES-1];
`endif

  // Previous conditioned sample for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b1;
    end else begin
      prev <= filt;
    end
  end

  assign level = filt;
  assign rise  = filt & ~prev;
  assign fall  = ~filt & prev;

endmodule

// File: rtl/i2c_target_regif.sv
// I2C target bridging bus transfers onto a byte-wide register port.
// Optional `I2C_TARGET_GLITCH_FILTER_EN enables a majority filter on SCL/SDA.
module i2c_target_regif #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h2a,
  parameter int         REG_AW      = 3,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic [REG_AW-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);
  import i2c_pkg::*;

  localparam logic [REG_AW-1:0] PTR_ONE = REG_AW'(1'b1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_tgt_state_e    state, state_nxt;
  logic [3:0]        bit_cnt, bit_cnt_nxt;
  logic [7:0]        shift, shift_nxt;
  logic [7:0]        rx_byte;
  logic [REG_AW-1:0] ptr_nxt;
  logic              sda_oe_nxt, busy_nxt, rw, rw_nxt, wr_en_nxt;
  logic [7:0]        wdata_nxt;

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_scl_cond (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_raw (scl_i),
    .level    (scl_lvl),
    .rise     (scl_rise),
    .fall     (scl_fall)
  );

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_sda_cond (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_raw (sda_i),
    .level    (sda_lvl),
    .rise     (sda_rise),
    .fall     (sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign rx_byte   = {shift[6:0], sda_lvl};

  // Next-state and datapath decode; SCL rise samples, SCL fall drives
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    ptr_nxt     = reg_addr;
    sda_oe_nxt  = sda_oe;
    busy_nxt    = busy;
    rw_nxt      = rw;
    wr_en_nxt   = 1'b0;
    wdata_nxt   = reg_wdata;
    if (stop_det) begin
      state_nxt   = ST_IDLE;
      bit_cnt_nxt = 4'd0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else if (start_det) begin
      state_nxt   = ST_ADDR;
      bit_cnt_nxt = 4'd0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == I2C_LAST_BIT) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state_nxt = ST_ADDR_ACK;
                busy_nxt  = 1'b1;
                rw_nxt    = rx_byte[0];
              end else begin
                state_nxt = ST_WAIT_STOP;
              end
            end else begin
              state_nxt = ST_ADDR;
            end
          end else begin
            state_nxt = ST_ADDR;
          end
        end
        ST_PTR: begin
          if (scl_rise) begin
            shift_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == I2C_LAST_BIT) begin
              ptr_nxt   = rx_byte[REG_AW-1:0];
              state_nxt = ST_PTR_ACK;
            end else begin
              state_nxt = ST_PTR;
            end
          end else begin
            state_nxt = ST_PTR;
          end
        end
        ST_WDATA: begin
          if (scl_rise) begin
            shift_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == I2C_LAST_BIT) begin
              wdata_nxt = rx_byte;
              wr_en_nxt = 1'b1;
              state_nxt = ST_WDATA_ACK;
            end else begin
              state_nxt = ST_WDATA;
            end
          end else begin
            state_nxt = ST_WDATA;
          end
        end
        // bit_cnt==8: fall opens the ACK slot; rise clears it; next fall closes it
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall && (bit_cnt == I2C_ACK_SLOT)) begin
            sda_oe_nxt = ~I2C_ACK;
          end else if (scl_rise) begin
            bit_cnt_nxt = 4'd0;
          end else if (scl_fall) begin
            bit_cnt_nxt = 4'd0;
            sda_oe_nxt  = 1'b0;
            if ((state == ST_ADDR_ACK) && (rw == I2C_RW_READ)) begin
              state_nxt  = ST_RDATA;
              shift_nxt  = reg_rdata;
              sda_oe_nxt = ~reg_rdata[7];
            end else if (state == ST_ADDR_ACK) begin
              state_nxt = ST_PTR;
            end else if (state == ST_WDATA_ACK) begin
              state_nxt = ST_WDATA;
              ptr_nxt   = reg_addr + PTR_ONE;
            end else begin
              state_nxt = ST_WDATA;
            end
          end else begin
            state_nxt = state;
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == I2C_ACK_SLOT) begin
              sda_oe_nxt = 1'b0;
              state_nxt  = ST_RDATA_ACK;
            end else begin
              shift_nxt  = {shift[6:0], 1'b0};
              sda_oe_nxt = ~shift[6];
            end
          end else begin
            state_nxt = ST_RDATA;
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_ACK) begin
              ptr_nxt     = reg_addr + PTR_ONE;
              bit_cnt_nxt = 4'd0;
            end else begin
              state_nxt = ST_WAIT_STOP;
            end
          end else if (scl_fall && (bit_cnt == 4'd0)) begin
            state_nxt  = ST_RDATA;
            shift_nxt  = reg_rdata;
            sda_oe_nxt = ~reg_rdata[7];
          end else begin
            state_nxt = ST_RDATA_ACK;
          end
        end
        ST_IDLE, ST_WAIT_STOP: begin
          state_nxt = state;
        end
        default: begin
          state_nxt  = ST_IDLE;
          sda_oe_nxt = 1'b0;
          busy_nxt   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset releases SDA asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'h00;
      reg_addr  <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      rw        <= I2C_RW_WRITE;
      reg_wr_en <= 1'b0;
      reg_wdata <= 8'h00;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      reg_addr  <= ptr_nxt;
      sda_oe    <= sda_oe_nxt;
      busy      <= busy_nxt;
      rw        <= rw_nxt;
      reg_wr_en <= wr_en_nxt;
      reg_wdata <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_target_regif.sv
// Directed bench for i2c_target_regif: bus-level master tasks plus a small register bank.
module tb_i2c_target_regif;

  localparam int Q = 625;

  logic       clk;
  logic       rst_n;
  logic       m_scl;
  logic       m_sda;
  logic       sda_bus;
  logic       sda_oe;
  logic [2:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  bank [8] = '{default: 8'h00};
  logic [10:0] strobe_q [$];
  int          oe_cycles = 0;

  assign sda_bus   = m_sda & ~sda_oe;
  assign reg_rdata = bank[reg_addr];

  i2c_target_regif #(
    .SLAVE_ADDR  (7'h2a),
    .REG_AW      (3),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (m_scl),
    .sda_i     (sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wr_en (reg_wr_en),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Host register bank plus strobe and SDA-drive monitors
  always @(negedge clk) begin
    if (reg_wr_en) begin
      bank[reg_addr] <= reg_wdata;
      strobe_q.push_back({reg_addr, reg_wdata});
    end
    if (sda_oe) oe_cycles <= oe_cycles + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    #Q;
    m_scl = 1'b1; #Q; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    b = sda_bus;  #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         base;
    int         oe_base;
    logic       exp_glitch_ack;

    rst_n = 1'b0;
    m_scl = 1'b1;
    m_sda = 1'b1;
    #103;
    check_eq("rst_sda_oe", sda_oe, 1'b0);
    check_eq("rst_reg_addr", reg_addr, 3'd0);
    check_eq("rst_wr_en", reg_wr_en, 1'b0);
    check_eq("rst_wdata", reg_wdata, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    #200;

    // write 2a/W, ptr 01, data 74
    base = strobe_q.size();
    i2c_start();
    write_byte(8'h54, ack); check_eq("t1_addr_ack", ack, 1'b0);
    check_eq("t1_busy", busy, 1'b1);
    write_byte(8'h01, ack); check_eq("t1_ptr_ack", ack, 1'b0);
    write_byte(8'h74, ack); check_eq("t1_data_ack", ack, 1'b0);
    i2c_stop();
    check_eq("t1_busy_stop", busy, 1'b0);
    check_eq("t1_strobes", strobe_q.size() - base, 1);
    check_eq("t1_strobe_addr", strobe_q[base][10:8], 3'd1);
    check_eq("t1_strobe_data", strobe_q[base][7:0], 8'h74);
    check_eq("t1_ptr_after", reg_addr, 3'd2);

    // pointer write then repeated START read, master NACK
    i2c_start();
    write_byte(8'h54, ack); check_eq("t2_addr_ack", ack, 1'b0);
    write_byte(8'h01, ack); check_eq("t2_ptr_ack", ack, 1'b0);
    i2c_start();
    write_byte(8'h55, ack); check_eq("t2_raddr_ack", ack, 1'b0);
    read_byte(rd, 1'b1);
    check_eq("t2_rdata", rd, 8'h74);
    check_eq("t2_oe_released", sda_oe, 1'b0);
    i2c_stop();
    check_eq("t2_ptr_after", reg_addr, 3'd1);

    // wrong address: NACK, no strobe, SDA never driven
    base    = strobe_q.size();
    oe_base = oe_cycles;
    i2c_start();
    write_byte(8'h56, ack); check_eq("t3_addr_nack", ack, 1'b1);
    write_byte(8'h99, ack); check_eq("t3_data_nack", ack, 1'b1);
    check_eq("t3_busy", busy, 1'b0);
    i2c_stop();
    check_eq("t3_strobes", strobe_q.size() - base, 0);
    check_eq("t3_oe_cycles", oe_cycles - oe_base, 0);

    // pointer wrap on write
    base = strobe_q.size();
    i2c_start();
    write_byte(8'h54, ack); check_eq("t4_addr_ack", ack, 1'b0);
    write_byte(8'h07, ack); check_eq("t4_ptr_ack", ack, 1'b0);
    write_byte(8'hA1, ack); check_eq("t4_d0_ack", ack, 1'b0);
    write_byte(8'hB2, ack); check_eq("t4_d1_ack", ack, 1'b0);
    i2c_stop();
    check_eq("t4_strobes", strobe_q.size() - base, 2);
    check_eq("t4_s0_addr", strobe_q[base][10:8], 3'd7);
    check_eq("t4_s0_data", strobe_q[base][7:0], 8'hA1);
    check_eq("t4_s1_addr", strobe_q[base + 1][10:8], 3'd0);
    check_eq("t4_s1_data", strobe_q[base + 1][7:0], 8'hB2);

    // three-byte read from 7 with wrap: A1, B2, 74
    i2c_start();
    write_byte(8'h54, ack); check_eq("t5_addr_ack", ack, 1'b0);
    write_byte(8'h07, ack); check_eq("t5_ptr_ack", ack, 1'b0);
    i2c_start();
    write_byte(8'h55, ack); check_eq("t5_raddr_ack", ack, 1'b0);
    read_byte(rd, 1'b0); check_eq("t5_rd0", rd, 8'hA1);
    check_eq("t5_ptr0", reg_addr, 3'd0);
    read_byte(rd, 1'b0); check_eq("t5_rd1", rd, 8'hB2);
    check_eq("t5_ptr1", reg_addr, 3'd1);
    read_byte(rd, 1'b1); check_eq("t5_rd2", rd, 8'h74);
    check_eq("t5_ptr2", reg_addr, 3'd1);
    i2c_stop();
    check_eq("t5_busy_stop", busy, 1'b0);

    // STOP after 4 data bits: no strobe; back in IDLE ignores bytes without START
    base = strobe_q.size();
    i2c_start();
    write_byte(8'h54, ack); check_eq("t6_addr_ack", ack, 1'b0);
    write_byte(8'h03, ack); check_eq("t6_ptr_ack", ack, 1'b0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    check_eq("t6_strobes", strobe_q.size() - base, 0);
    check_eq("t6_busy", busy, 1'b0);
    check_eq("t6_ptr", reg_addr, 3'd3);
    m_scl = 1'b0; #Q;
    write_byte(8'h54, ack); check_eq("t6_idle_nack", ack, 1'b1);
    i2c_stop();

    // async reset while ACK is driven
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(((8'h54 >> i) & 8'h01) != 8'h00);
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    check_eq("t7_ack_driven", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("t7_rst_oe", sda_oe, 1'b0);
    check_eq("t7_rst_busy", busy, 1'b0);
    #Q;
    m_scl = 1'b0; #Q;
    i2c_stop();
    rst_n = 1'b1;
    #Q;

    // 1-clk SDA high pulse while SCL high, SDA low, no real START
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    exp_glitch_ack = 1'b1;
`else
    exp_glitch_ack = 1'b0;
`endif
    m_scl = 1'b0; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    @(negedge clk);
    m_sda = 1'b1;
    @(negedge clk);
    m_sda = 1'b0;
    #3;
    #Q;
    m_scl = 1'b0; #Q;
    write_byte(8'h54, ack);
    check_eq("t8_glitch_ack", ack, exp_glitch_ack);
    i2c_stop();
    check_eq("t8_oe_end", sda_oe, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
